// File: rtl/maxpool2x2_tensor_seq_pkg.sv
// Shared definitions for the 2x2 max-pool stage: FSM encoding, default geometry
// and the flat-tensor offset helper also used by the relu/conv wrappers.
package maxpool2x2_tensor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BATCH_SIZE = 1;
  localparam int DEF_CHANNELS   = 1;
  localparam int DEF_HEIGHT     = 4;
  localparam int DEF_WIDTH      = 4;
  localparam int DEF_OH         = DEF_HEIGHT / 2;
  localparam int DEF_OW         = DEF_WIDTH / 2;
  localparam int DEF_N_OUT      = DEF_BATCH_SIZE * DEF_CHANNELS * DEF_OH * DEF_OW;

  function automatic int calc_n_out(input int b, input int c, input int h, input int w);
    return b * c * (h / 2) * (w / 2);
  endfunction

  // A single-element result still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of element (b,c,h,w) in a flat NCHW tensor.
  function automatic int elem_off(input int b, input int c, input int h, input int w,
                                  input int chans, input int hgt, input int wid,
                                  input int dw);
    return (((b * chans + c) * hgt + h) * wid + w) * dw;
  endfunction

endpackage

// File: rtl/maxpool2x2_tensor_seq_max4.sv
// Combinational signed max of four elements; tie order does not matter since
// equal operands give the same value.
module max4_signed #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0][DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0]      y
);

  logic [DATA_WIDTH-1:0] m01, m23;

  assign m01 = ($signed(x[0]) > $signed(x[1])) ? x[0] : x[1];
  assign m23 = ($signed(x[2]) > $signed(x[3])) ? x[2] : x[3];
  assign y   = ($signed(m01) > $signed(m23)) ? m01 : m23;

endmodule

// File: rtl/maxpool2x2_tensor_seq.sv
// Sequential 2x2/stride-2 max pool over a flat NCHW tensor: one pooled element
// per cycle through a single 4-way comparator, valid/ready on both sides.
module maxpool2x2_tensor_seq
  import maxpool2x2_tensor_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BATCH_SIZE = DEF_BATCH_SIZE,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic                                                      in_valid,
  output logic                                                      in_ready,
  input  logic [BATCH_SIZE*CHANNELS*HEIGHT*WIDTH*DATA_WIDTH-1:0]    in_tensor,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic [BATCH_SIZE*CHANNELS*(HEIGHT/2)*(WIDTH/2)*DATA_WIDTH-1:0] out_tensor,
  output logic                                                      busy
);

  localparam int OH    = HEIGHT / 2;
  localparam int OW    = WIDTH / 2;
  localparam int N_OUT = calc_n_out(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH);
  localparam int CW    = calc_cnt_w(N_OUT);
  localparam int IN_W  = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH * DATA_WIDTH;
  localparam int OUT_W = N_OUT * DATA_WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_OUT - 1);

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt;
  logic [IN_W-1:0]              in_buf;
  logic [OUT_W-1:0]             out_buf;
  logic [3:0][DATA_WIDTH-1:0]   win;
  logic [DATA_WIDTH-1:0]        pool_max;
  int                           k, plane, oh, ow;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_tensor = out_buf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Decode k into (plane, oh, ow) and gather its 2x2 input window.
  always_comb begin
    k     = int'(cnt);
    ow    = k % OW;
    oh    = (k / OW) % OH;
    plane = k / (OW * OH);
    win   = '0;
    for (int j = 0; j < 4; j++)
      win[j] = in_buf[elem_off(plane / CHANNELS, plane % CHANNELS, 2 * oh + j / 2,
                               2 * ow + j % 2, CHANNELS, HEIGHT, WIDTH, DATA_WIDTH)
                      +: DATA_WIDTH];
  end

  max4_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max4 (
    .x (win),
    .y (pool_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      in_buf  <= '0;
      out_buf <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_buf <= in_tensor;
          cnt    <= '0;
        end
        RUN: begin
          out_buf[k * DATA_WIDTH +: DATA_WIDTH] <= pool_max;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2x2_tensor_seq.sv
// Drives two pool instances (4x4x1 and 2x4x2 geometry) with shared stimulus and
// compares both against a plain-arithmetic pooling model.
module tb_maxpool2x2_tensor_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, out_ready;
  logic [511:0] in_tensor;
  logic         in_ready0, out_valid0, busy0;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] out0, out1;

  int n_chk = 0;
  int n_err = 0;
  int x [16];
  int y0 [4];
  int y1 [4];
  logic [127:0] snap;

  always #5 clk = ~clk;

  maxpool2x2_tensor_seq u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_tensor(in_tensor), .out_valid(out_valid0), .out_ready(out_ready),
    .out_tensor(out0), .busy(busy0)
  );

  maxpool2x2_tensor_seq #(.CHANNELS(2), .HEIGHT(2), .WIDTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_tensor(in_tensor), .out_valid(out_valid1), .out_ready(out_ready),
    .out_tensor(out1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pool the 16 model elements viewed as C x H x W planes.
  task automatic pool_ref(input int c_n, input int h_n, input int w_n, output int y [4]);
    int m, v;
    for (int c = 0; c < c_n; c++)
      for (int oh = 0; oh < h_n / 2; oh++)
        for (int ow = 0; ow < w_n / 2; ow++) begin
          m = x[(c * h_n + 2 * oh) * w_n + 2 * ow];
          for (int dh = 0; dh < 2; dh++)
            for (int dw = 0; dw < 2; dw++) begin
              v = x[(c * h_n + 2 * oh + dh) * w_n + 2 * ow + dw];
              if (v > m) m = v;
            end
          y[(c * (h_n / 2) + oh) * (w_n / 2) + ow] = m;
        end
  endtask

  task automatic pack();
    for (int i = 0; i < 16; i++) in_tensor[i*32 +: 32] = x[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit hold);
    int n = 0;
    pack();
    in_valid = 1'b1;
    while (!in_ready0 && n < 20) begin step(); n++; end
    chk("acc_ready", in_ready0, 1'b1);
    step();
    if (!hold) in_valid = 1'b0;
    chk("run_busy", busy0, 1'b1);
    chk("run_in_ready", in_ready0, 1'b0);
  endtask

  task automatic wait_out(input string tag);
    int lat = 0;
    while (!out_valid0 && lat < 20) begin step(); lat++; end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_ov1"}, out_valid1, 1'b1);
  endtask

  task automatic check_out(input string tag);
    pool_ref(1, 4, 4, y0);
    pool_ref(2, 2, 4, y1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_d0_e%0d", tag, i), out0[i*32 +: 32], y0[i]);
      chk($sformatf("%s_d1_e%0d", tag, i), out1[i*32 +: 32], y1[i]);
    end
  endtask

  task automatic rand_x();
    for (int i = 0; i < 16; i++) x[i] = int'($urandom());
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_tensor = '0;
    step(); step();
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_out_zero", out0 == '0 && out1 == '0, 1'b1);
    reset = 1'b1;
    step();

    // Ramp 0..15
    for (int i = 0; i < 16; i++) x[i] = i;
    accept(0); wait_out("ramp"); check_out("ramp");
    chk("ramp_c0", out0[31:0], 32'd5);   chk("ramp_c1", out0[63:32], 32'd7);
    chk("ramp_c2", out0[95:64], 32'd13); chk("ramp_c3", out0[127:96], 32'd15);
    step();
    chk("ramp_idle_ready", in_ready0, 1'b1);
    chk("ramp_idle_ov", out_valid0, 1'b0);

    // Signed window
    for (int i = 0; i < 16; i++) x[i] = -100;
    x[0] = -3; x[1] = -1; x[4] = -7; x[5] = -2;
    accept(0); wait_out("sgn"); check_out("sgn");
    chk("sgn_c0", out0[31:0], 32'hFFFF_FFFF);
    chk("sgn_c1", out0[63:32], 32'hFFFF_FF9C);
    step();

    // Two-channel geometry on dut1
    for (int i = 0; i < 16; i++) x[i] = (i < 8) ? i : 100 + i - 8;
    accept(0); wait_out("ch2"); check_out("ch2");
    chk("ch2_c0", out1[31:0], 32'd5);    chk("ch2_c1", out1[63:32], 32'd7);
    chk("ch2_c2", out1[95:64], 32'd105); chk("ch2_c3", out1[127:96], 32'd107);
    step();

    // Backpressure in DONE
    out_ready = 1'b0;
    rand_x(); accept(0); wait_out("bp"); check_out("bp");
    snap = out0;
    repeat (10) step();
    chk("bp_ov", out_valid0, 1'b1);
    chk("bp_ir", in_ready0, 1'b0);
    chk("bp_busy", busy0, 1'b1);
    chk("bp_stable", out0 == snap, 1'b1);
    out_ready = 1'b1;
    step();
    chk("bp_rel_ir", in_ready0, 1'b1);
    chk("bp_rel_ov", out_valid0, 1'b0);
    chk("bp_rel_busy", busy0, 1'b0);

    // Reset while counter == 2
    rand_x(); accept(0); step(); step();
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid0, 1'b0);
    chk("mid_rst_ir", in_ready0, 1'b1);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_out0", out0 == '0 && out1 == '0, 1'b1);
    #2 reset = 1'b1;
    step();
    rand_x(); accept(0); wait_out("post_rst"); check_out("post_rst");
    step();

    // Back-to-back with in_valid held high
    rand_x(); accept(1); wait_out("bbA"); check_out("bbA");
    rand_x(); pack();
    step();
    chk("bb_idle_ir", in_ready0, 1'b1);
    chk("bb_idle_ov", out_valid0, 1'b0);
    step();
    chk("bb_second_acc", busy0, 1'b1);
    in_valid = 1'b0;
    wait_out("bbB"); check_out("bbB");
    step(); step();
    chk("bb_no_dup", busy0, 1'b0);

    // Random tensors
    for (int r = 0; r < 6; r++) begin
      rand_x(); accept(0); wait_out("rnd"); check_out($sformatf("rnd%0d", r));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
